// File: rtl/agc_word_pkg.sv
// agc_word_pkg: shared 16-bit AGC memory word layout and odd-parity helper
package agc_word_pkg;
  localparam int WORD_W = 16;
  localparam int DATA_W = 15;
  localparam int PAR_BIT = 0;
  localparam logic [DATA_W-1:0] MINUS_ZERO = 15'h7FFF;
  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/agc_parity_writer_if.sv
// agc_parity_writer_if: ALU result input channel and memory write channel
interface agc_parity_writer_if #(parameter int ADDR_W = 12);
  import agc_word_pkg::*;
  logic res_valid;
  logic res_ready;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_addr;
  logic force_bad_par;
  logic mem_valid;
  logic mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  modport master(output res_valid, res_data, res_addr, force_bad_par, mem_ready,
                 input res_ready, mem_valid, mem_addr, mem_wdata);
  modport slave(input res_valid, res_data, res_addr, force_bad_par, mem_ready,
                output res_ready, mem_valid, mem_addr, mem_wdata);
endinterface

// File: rtl/agc_sync_fifo.sv
// agc_sync_fifo: pointer-based synchronous FIFO; output holds the last popped word when empty
module agc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = empty ? last : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      last <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) begin
        rp <= rp + AW'(1);
        last <= mem[rp];
      end
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/agc_parity_writer.sv
// agc_parity_writer: adds odd parity to ALU results and queues them as memory writes
module agc_parity_writer
  import agc_word_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 12,
  parameter bit NORM_MZ = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  agc_parity_writer_if.slave bus,
  output logic [15:0] words_written,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int W = WORD_W + ADDR_W;
  logic [DATA_W-1:0] d;
  logic [W-1:0] entry, head;
  logic full, empty;
  assign d = (NORM_MZ && bus.res_data == MINUS_ZERO) ? '0 : bus.res_data;
  assign entry = {d, odd_parity(d) ^ bus.force_bad_par, bus.res_addr};
  agc_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(bus.res_valid),
    .pop(bus.mem_ready),
    .din(entry),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign bus.res_ready = !full;
  assign bus.mem_valid = !empty;
  assign bus.mem_wdata = head[W-1:ADDR_W];
  assign bus.mem_addr = head[ADDR_W-1:0];
  always_ff @(posedge clk) begin
    if (!reset_n) words_written <= '0;
    else if (bus.mem_valid && bus.mem_ready) words_written <= words_written + 16'd1;
  end
endmodule

// File: tb/tb_agc_parity_writer.sv
// tb_agc_parity_writer: directed and random checks against a queue model of the parity writer
module tb_agc_parity_writer;
  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] ww0, ww1;
  logic [2:0] fc0, fc1;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [11:0] a;
    logic [15:0] w;
  } ent_t;
  ent_t q[$];
  logic [15:0] ww_m, last_w, ww_start;
  logic [11:0] last_a;
  always #5 clk = ~clk;
  agc_parity_writer_if #(.ADDR_W(12)) b0 ();
  agc_parity_writer_if #(.ADDR_W(12)) b1 ();
  assign b1.res_valid = b0.res_valid;
  assign b1.res_data = b0.res_data;
  assign b1.res_addr = b0.res_addr;
  assign b1.force_bad_par = b0.force_bad_par;
  assign b1.mem_ready = 1'b1;
  agc_parity_writer #(.DEPTH(4), .ADDR_W(12), .NORM_MZ(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave), .words_written(ww0), .fifo_count(fc0));
  agc_parity_writer #(.DEPTH(4), .ADDR_W(12), .NORM_MZ(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave), .words_written(ww1), .fifo_count(fc1));
  function automatic logic [15:0] mkword(input logic [14:0] data, input bit norm, input bit bad);
    logic [14:0] d;
    d = (norm && data == 15'h7FFF) ? 15'h0 : data;
    return {d, logic'(($countones(d) % 2 == 0) ^ bad)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("res_ready", 32'(b0.res_ready), 32'(q.size() < 4));
    chk("mem_valid", 32'(b0.mem_valid), 32'(q.size() > 0));
    chk("fifo_count", 32'(fc0), 32'(q.size()));
    chk("words_written", 32'(ww0), 32'(ww_m));
    chk("mem_wdata", 32'(b0.mem_wdata), 32'(q.size() > 0 ? q[0].w : last_w));
    chk("mem_addr", 32'(b0.mem_addr), 32'(q.size() > 0 ? q[0].a : last_a));
  endtask
  task automatic step();
    bit push, pop;
    push = b0.res_valid && q.size() < 4;
    pop = q.size() > 0 && b0.mem_ready;
    if (!reset_n) begin
      q.delete();
      ww_m = '0;
      last_w = '0;
      last_a = '0;
    end else begin
      if (pop) begin
        last_w = q[0].w;
        last_a = q[0].a;
        void'(q.pop_front());
        ww_m = ww_m + 16'd1;
      end
      if (push) q.push_back('{a: b0.res_addr, w: mkword(b0.res_data, 1'b0, b0.force_bad_par)});
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic one_word(input string tag, input logic [14:0] data, input logic [11:0] a,
                          input bit bad, input logic [15:0] exp);
    b0.res_valid = 1'b1;
    b0.res_data = data;
    b0.res_addr = a;
    b0.force_bad_par = bad;
    b0.mem_ready = 1'b1;
    step();
    chk(tag, 32'(b0.mem_wdata), 32'(exp));
    b0.res_valid = 1'b0;
    b0.force_bad_par = 1'b0;
    step();
  endtask
  initial begin
    reset_n = 1'b0;
    b0.res_valid = 1'b0;
    b0.res_data = '0;
    b0.res_addr = '0;
    b0.force_bad_par = 1'b0;
    b0.mem_ready = 1'b0;
    q.delete();
    ww_m = '0;
    last_w = '0;
    last_a = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
    // directed word formats
    b0.res_valid = 1'b1;
    b0.res_data = 15'h7FFF;
    b0.res_addr = 12'h020;
    b0.mem_ready = 1'b1;
    step();
    chk("nmz0_minus_zero", 32'(b0.mem_wdata), 32'h0000FFFE);
    chk("nmz1_minus_zero", 32'(b1.mem_wdata), 32'h00000001);
    b0.res_valid = 1'b0;
    step();
    one_word("w3fff", 15'h3FFF, 12'h010, 1'b0, 16'h7FFF);
    chk("addr_010_written", 32'(last_a), 32'(12'h010));
    one_word("w153", 15'd153, 12'h011, 1'b0, 16'h0133);
    one_word("wm153", 15'h7F66, 12'h012, 1'b0, 16'hFECC);
    one_word("wzero", 15'h0000, 12'h013, 1'b0, 16'h0001);
    one_word("badpar", 15'd153, 12'h014, 1'b1, 16'h0132);
    chk("ww_after_directed", 32'(ww0), 32'd6);
    // fill to full with memory stalled, fifth push refused
    b0.mem_ready = 1'b0;
    b0.res_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b0.res_data = 15'($urandom);
      b0.res_addr = 12'($urandom);
      step();
      if (i == 3) chk("full_after_4", 32'(b0.res_ready), 32'd0);
    end
    b0.res_valid = 1'b0;
    step();
    b0.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drained", 32'(fc0), 32'd0);
    // streaming: one write per cycle
    ww_start = ww_m;
    b0.res_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b0.res_data = 15'($urandom);
      b0.res_addr = 12'($urandom);
      step();
      chk("stream_count", 32'(fc0), 32'd1);
    end
    b0.res_valid = 1'b0;
    step();
    chk("stream_written", 32'(ww0), 32'(ww_start + 16'd10));
    // random traffic
    for (int i = 0; i < 300; i++) begin
      b0.res_valid = 1'($urandom);
      b0.res_data = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom);
      b0.res_addr = 12'($urandom);
      b0.force_bad_par = ($urandom_range(0, 9) == 0);
      b0.mem_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    b0.force_bad_par = 1'b0;
    b0.res_valid = 1'b0;
    b0.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    // reset with three queued entries and a push pending
    b0.mem_ready = 1'b0;
    b0.res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b0.res_data = 15'($urandom);
      b0.res_addr = 12'($urandom);
      step();
    end
    reset_n = 1'b0;
    b0.res_data = 15'h1234;
    step();
    chk("rst_count", 32'(fc0), 32'd0);
    chk("rst_written", 32'(ww0), 32'd0);
    chk("rst_valid", 32'(b0.mem_valid), 32'd0);
    reset_n = 1'b1;
    b0.res_valid = 1'b0;
    b0.mem_ready = 1'b1;
    step();
    step();
    chk("rst_no_write", 32'(ww0), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
